// File: rtl/psum_if.sv
// Kernel-channel PE output bus: per-lane psum word in, FIFO head word out.
interface psum_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4
);
  logic [BIT_WIDTH*NUM_KERNEL-1:0] i_psum;
  logic [NUM_KERNEL-1:0]           i_psum_val;
  logic [BIT_WIDTH*NUM_KERNEL-1:0] o_data;
  logic                            o_data_val;
  logic                            i_data_rdy;

  modport master (output i_psum, i_psum_val, i_data_rdy, input o_data, o_data_val);
  modport slave  (input i_psum, i_psum_val, i_data_rdy, output o_data, o_data_val);
endinterface

// File: rtl/psum_collector.sv
// Collects coherent PE partial-sum words into a FWFT FIFO, drains them to
// writeback and tracks the job word count, completion and sticky errors.
module psum_lane #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [BIT_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [BIT_WIDTH-1:0] o_rdata
);
  logic [BIT_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

module psum_collector #(
  parameter int BIT_WIDTH    = 8,
  parameter int NUM_KERNEL   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 3,
  parameter int CNT_WIDTH    = 16,
  parameter int REG_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_num_out,
  psum_if.slave                s,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_count,
  input  logic                 i_err_clr,
  output logic [REG_WIDTH-1:0] err_psum_val
);
  localparam int            AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LP_MARGIN = (AW+1)'(STALL_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_fill, w_fill_nxt;
  logic [CNT_WIDTH-1:0]   r_num, r_count, w_cnt_inc;
  logic                   r_stall, r_done;
  logic [REG_WIDTH-1:0]   r_err, w_set;
  logic                   w_all, w_none, w_run, w_empty, w_full, w_rd, w_wr, w_room, w_cnt_max;

  logic [NUM_KERNEL-1:0][BIT_WIDTH-1:0] w_wlane, w_rlane;

  assign w_all     = &s.i_psum_val;
  assign w_none    = ~|s.i_psum_val;
  assign w_run     = (r_state == S_RUN);
  assign w_empty   = (r_fill == '0);
  assign w_full    = (r_fill == LP_DEPTH);
  assign w_rd      = !w_empty && s.i_data_rdy;
  assign w_room    = !w_full || w_rd;
  assign w_cnt_max = &r_count;
  assign w_cnt_inc = r_count + CNT_WIDTH'(1);
  assign w_wr      = w_run && w_all && w_room && !w_cnt_max;

  always_comb begin
    w_set    = '0;
    w_set[0] = !w_all && !w_none;
    w_set[1] = w_run && w_all && !w_room;
    w_set[2] = w_all && !w_run;
    w_set[3] = w_run && w_all && w_room && w_cnt_max;
  end

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_wr, w_rd})
      2'b10:   w_fill_nxt = r_fill + (AW+1)'(1);
      2'b01:   w_fill_nxt = r_fill - (AW+1)'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_num   <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_fill  <= w_fill_nxt;
      r_stall <= (LP_DEPTH - w_fill_nxt) <= LP_MARGIN;
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      // a new error in the clearing cycle survives the clear
      r_err   <= (i_err_clr ? '0 : r_err) | w_set;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE:
          if (i_start) begin
            r_num   <= i_num_out;
            r_count <= '0;
            if (i_num_out == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        S_RUN:
          if (w_wr) begin
            r_count <= w_cnt_inc;
            if (w_cnt_inc == r_num) r_state <= S_DRAIN;
          end
        S_DRAIN:
          if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        S_DONE:
          r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wlane = s.i_psum;

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
    psum_lane #(.BIT_WIDTH(BIT_WIDTH), .DEPTH(FIFO_DEPTH), .AW(AW)) u_lane (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr (r_wptr),
      .i_wdata (w_wlane[k]),
      .i_raddr (r_rptr),
      .o_rdata (w_rlane[k])
    );
  end

  // head is masked so stale storage never shows while empty
  assign s.o_data     = w_empty ? '0 : w_rlane;
  assign s.o_data_val = !w_empty;
  assign o_stall      = r_stall;
  assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done       = r_done;
  assign o_count      = r_count;
  assign err_psum_val = r_err;
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector; a negedge monitor checks drained words
// against a queue of words the stimulus expects to be accepted.
module tb_psum_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_num_out = '0;
  logic        i_err_clr = 1'b0;
  logic        o_stall, o_busy, o_done;
  logic [15:0] o_count;
  logic [31:0] err_psum_val;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  psum_if #(.BIT_WIDTH(8), .NUM_KERNEL(4)) dif();

  psum_collector #(
    .BIT_WIDTH(8), .NUM_KERNEL(4), .FIFO_DEPTH(8), .STALL_MARGIN(3),
    .CNT_WIDTH(16), .REG_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_num_out    (i_num_out),
    .s            (dif),
    .o_stall      (o_stall),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_count      (o_count),
    .i_err_clr    (i_err_clr),
    .err_psum_val (err_psum_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // read happens at the next posedge when valid and ready are both high here
  always @(negedge clk) begin
    if (rst && dif.o_data_val && dif.i_data_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got %0h expected no word", dif.o_data);
      end else begin
        chk("sb_word", dif.o_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit acc);
    dif.i_psum     = w;
    dif.i_psum_val = 4'hF;
    if (acc) sb.push_back(w);
    tick();
    dif.i_psum_val = 4'h0;
  endtask

  task automatic start_job(input logic [15:0] n);
    i_start   = 1'b1;
    i_num_out = n;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic clear_err();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
  endtask

  // waits for o_done, checks busy drops with it and the pulse lasts one cycle
  task automatic wait_done(input string name, input int maxc, output int cyc);
    cyc = -1;
    for (int i = 0; i < maxc; i++) begin
      if (o_done) begin
        cyc = i;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, (cyc >= 0), 1);
    chk({name, "_busy_at_done"}, o_busy, 0);
    tick();
    chk({name, "_done_one_cycle"}, o_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int dones;
    dif.i_psum     = '0;
    dif.i_psum_val = '0;
    dif.i_data_rdy = 1'b0;
    #2 rst = 1'b0;
    repeat (2) tick();
    chk("rst_data_val", dif.o_data_val, 0);
    chk("rst_data",     dif.o_data, 0);
    chk("rst_stall",    o_stall, 0);
    chk("rst_busy",     o_busy, 0);
    chk("rst_done",     o_done, 0);
    chk("rst_count",    o_count, 0);
    chk("rst_err",      err_psum_val, 0);
    rst = 1'b1;
    tick();

    // complete word in IDLE is dropped and flagged
    send(32'hDEADBEEF, 0);
    chk("idle_err", err_psum_val, 32'h4);
    chk("idle_empty", dif.o_data_val, 0);
    clear_err();
    chk("idle_err_clr", err_psum_val, 0);

    // basic job, downstream always ready
    dif.i_data_rdy = 1'b1;
    start_job(16'd5);
    chk("basic_busy", o_busy, 1);
    chk("basic_count0", o_count, 0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      w = 32'h04030201 + 32'h04040404 * i;
      send(w, 1);
      chk("basic_latency", dif.o_data, w);
    end
    chk("basic_count", o_count, 5);
    wait_done("basic", 10, cyc);
    chk("basic_count_hold", o_count, 5);

    // back-pressure: 8 accepted, 2 dropped
    dif.i_data_rdy = 1'b0;
    start_job(16'd10);
    for (int i = 0; i < 10; i++) begin
      send({4{8'hA0 + 8'(i)}}, i < 8);
      if (i == 3) chk("bp_stall_4", o_stall, 0);
      if (i == 4) chk("bp_stall_5", o_stall, 1);
    end
    chk("bp_count", o_count, 8);
    chk("bp_err",   err_psum_val, 32'h2);
    chk("bp_full_val", dif.o_data_val, 1);
    clear_err();
    dif.i_data_rdy = 1'b1;
    repeat (8) tick();
    chk("bp_drained", dif.o_data_val, 0);
    chk("bp_still_run", o_busy, 1);
    chk("bp_no_done", o_done, 0);
    chk("bp_stall_off", o_stall, 0);
    send(32'hB1B1B1B1, 1);
    send(32'hB2B2B2B2, 1);
    wait_done("bp", 10, cyc);
    chk("bp_count_end", o_count, 10);

    // full FIFO with a read in the same cycle still accepts
    dif.i_data_rdy = 1'b0;
    start_job(16'd12);
    for (int i = 0; i < 8; i++) send({4{8'hC0 + 8'(i)}}, 1);
    chk("full_stall", o_stall, 1);
    dif.i_data_rdy = 1'b1;
    send(32'hC8C8C8C8, 1);
    dif.i_data_rdy = 1'b0;
    chk("full_rw_count", o_count, 9);
    chk("full_rw_err",   err_psum_val, 0);
    chk("full_rw_stall", o_stall, 1);

    // partial lane valid
    dif.i_psum     = 32'h77777777;
    dif.i_psum_val = 4'b0111;
    tick();
    dif.i_psum_val = 4'h0;
    chk("partial_err",   err_psum_val, 32'h1);
    chk("partial_count", o_count, 9);
    clear_err();
    chk("partial_clr", err_psum_val, 0);
    dif.i_data_rdy = 1'b1;
    for (int i = 9; i < 12; i++) send({4{8'hC0 + 8'(i)}}, 1);
    wait_done("full", 20, cyc);
    chk("full_count_end", o_count, 12);

    // zero-length job
    start_job(16'd0);
    wait_done("zero", 3, cyc);
    chk("zero_latency", (cyc >= 0 && cyc <= 1), 1);
    chk("zero_count", o_count, 0);

    // async reset in DRAIN with 3 words buffered
    dif.i_data_rdy = 1'b0;
    start_job(16'd3);
    for (int i = 0; i < 3; i++) send({4{8'hE0 + 8'(i)}}, 1);
    chk("mid_busy", o_busy, 1);
    chk("mid_val",  dif.o_data_val, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_val",   dif.o_data_val, 0);
    chk("mid_rst_data",  dif.o_data, 0);
    chk("mid_rst_busy",  o_busy, 0);
    chk("mid_rst_count", o_count, 0);
    sb.delete();
    #3 rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done) dones++;
    end
    chk("mid_no_done", dones, 0);
    chk("mid_idle", o_busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
